// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: turns held direction keys into a stream of moves with an
// initial delay and a steady auto-repeat, buffered in a 4-entry FIFO.
//
// Ports:
//   pxl_clk      clock; all state changes on its rising edge
//   reset_n      asynchronous active-low reset
//   left/down/up/right  level key-held flags, synchronous to pxl_clk
//   tick         single-cycle timebase pulse
//   move_ready   consumer accepts the head move
//   move_valid   FIFO non-empty, head move presented on move_dir
//   move_dir     head move: 0=left, 1=down, 2=up, 3=right
//   fifo_count   FIFO occupancy 0..4
//   drop         one-cycle pulse when a move is lost to a full FIFO
module key_repeat_ctrl #(
  parameter int unsigned DELAY_TICKS  = 20,
  parameter int unsigned REPEAT_TICKS = 4
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       left,
  input  logic       down,
  input  logic       up,
  input  logic       right,
  input  logic       tick,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [2:0] fifo_count,
  output logic       drop
);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  state_e     state_q, state_d;
  logic [1:0] active_q, active_d;
  logic [7:0] cnt_q, cnt_d;

  // Bit index equals the direction code.
  logic [3:0] keys, key_q, press;
  logic       press_any;
  logic [1:0] press_dir;

  logic       push;
  logic [1:0] push_dir;

  logic [1:0] mem_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic       drop_q;
  logic       full, pop, wr_en;

  assign keys      = {right, up, down, left};
  assign press     = keys & ~key_q;
  assign press_any = |press;

  // Fixed priority up > down > left > right.
  always_comb begin
    press_dir = 2'd3;
    if (press[2])      press_dir = 2'd2;
    else if (press[1]) press_dir = 2'd1;
    else if (press[0]) press_dir = 2'd0;
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_dir = active_q;
    unique case (state_q)
      StIdle: begin
        if (press_any) begin
          push     = 1'b1;
          push_dir = press_dir;
          active_d = press_dir;
          cnt_d    = 8'(DELAY_TICKS);
          state_d  = StDelay;
        end
      end
      StDelay, StRepeat: begin
        // New press beats release, which beats tick.
        if (press_any) begin
          push     = 1'b1;
          push_dir = press_dir;
          active_d = press_dir;
          cnt_d    = 8'(DELAY_TICKS);
          state_d  = StDelay;
        end else if (!keys[active_q]) begin
          state_d = StIdle;
        end else if (tick) begin
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            push    = 1'b1;
            cnt_d   = 8'(REPEAT_TICKS);
            state_d = StRepeat;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      active_q <= 2'd0;
      cnt_q    <= 8'd0;
      key_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      key_q    <= keys;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full  = (fifo_cnt_q == 3'd4);
  assign pop   = move_valid && move_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (wr_en && !pop)      fifo_cnt_d = fifo_cnt_q + 3'd1;
    else if (!wr_en && pop) fifo_cnt_d = fifo_cnt_q - 3'd1;
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 2'd0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      fifo_cnt_q <= 3'd0;
      drop_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q] <= push_dir;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_d;
      drop_q     <= push && full && !pop;
    end
  end

  assign move_valid = (fifo_cnt_q != 3'd0);
  assign move_dir   = move_valid ? mem_q[rptr_q] : 2'd0;
  assign fifo_count = fifo_cnt_q;
  assign drop       = drop_q;

endmodule

// File: doc/key_repeat_ctrl.md
KEY_REPEAT_CTRL -- requirements
Module: key_repeat_ctrl

Interface
REQ-001 SHALL have parameter DELAY_TICKS, default 20: ticks from the initial move to the first auto-repeat move; legal range 1..255.
REQ-002 SHALL have parameter REPEAT_TICKS, default 4: ticks between successive auto-repeat moves; legal range 1..255.
REQ-003 SHALL have port pxl_clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports left, down, up, right, inputs, 1 bit each: level key-held flags, already synchronous to pxl_clk.
REQ-006 SHALL have port tick, input, 1 bit: single-cycle timebase pulse (e.g. once per frame).
REQ-007 SHALL have port move_ready, input, 1 bit: consumer accepts the head move.
REQ-008 SHALL have port move_valid, output, 1 bit: FIFO non-empty, head move presented.
REQ-009 SHALL have port move_dir, output, 2 bits: head move; 0=left, 1=down, 2=up, 3=right.
REQ-010 SHALL have port fifo_count, output, 3 bits: FIFO occupancy, 0..4.
REQ-011 SHALL have port drop, output, 1 bit: one-cycle pulse when a move is lost because the FIFO is full.

Function
REQ-012 SHALL register each key input and detect a press when the key is sampled 1 at an edge after being sampled 0 at the previous edge.
REQ-013 SHALL resolve simultaneous new presses by fixed priority up > down > left > right; lower-priority simultaneous presses generate no move.
REQ-014 SHALL implement FSM states IDLE, DELAY, REPEAT, with an active-key register (2 bits) and an 8-bit tick counter.
REQ-015 IDLE: on a new press SHALL enqueue that direction, latch it as the active key, load the counter with DELAY_TICKS, and go to DELAY.
REQ-016 DELAY/REPEAT: a new press of any other key SHALL take precedence over every other event: enqueue it, make it active, reload DELAY_TICKS, and go to DELAY.
REQ-017 DELAY/REPEAT: when the active key is sampled 0 (and there is no new press), the FSM SHALL go to IDLE without enqueuing; keys still held generate no move until re-pressed.
REQ-018 DELAY/REPEAT: on tick with counter > 1, the counter SHALL decrement; on tick with counter == 1, the FSM SHALL enqueue the active key, load REPEAT_TICKS, and go or stay in REPEAT.
REQ-019 Counter and state SHALL be unaffected in cycles without tick, except as defined in REQ-015 to REQ-017.
REQ-020 SHALL provide a 4-entry FIFO; a pop occurs when move_valid && move_ready; a push occurs on an enqueue.
REQ-021 Latency: move_valid SHALL assert in the cycle following the edge that detected the press, given an empty FIFO.
REQ-022 Full FIFO with a push and no pop: the push SHALL be discarded, drop SHALL pulse for one cycle, and FSM state and counter SHALL still advance.
REQ-023 Full FIFO with a push and a pop in the same cycle: both SHALL succeed, fifo_count SHALL stay 4, and drop SHALL stay 0.
REQ-024 Empty FIFO with a push: move_valid SHALL not assert before the following cycle (no bypass).
REQ-025 move_dir and move_valid SHALL hold stable while move_valid && !move_ready.
REQ-026 Read and write pointers SHALL wrap modulo 4.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, counter 0, FIFO empty, move_valid 0, move_dir 0, fifo_count 0, drop 0, and key history registers 0.
REQ-028 A key already held when reset_n deasserts SHALL count as a new press on the first sampled edge.
REQ-029 Reset asserted mid-DELAY or mid-REPEAT SHALL discard all pending moves and timing.

Verification
REQ-030 Tap: up high for 3 cycles, move_ready=1 -> exactly one move, move_dir=2, move_valid high for 1 cycle, one cycle after the press edge.
REQ-031 Hold: DELAY_TICKS=3, REPEAT_TICKS=2, right held for 10 ticks -> moves after the press and on ticks 3, 5, 7, 9; 5 moves total, all move_dir=3.
REQ-032 Priority: left and up rise on the same edge -> a single move, move_dir=2; left stays silent while up is held; release up while left is still held -> no further move.
REQ-033 Overflow: move_ready=0, 5 distinct presses -> fifo_count=4, drop pulses once, and the head remains the first move.
REQ-034 Full with simultaneous push and pop -> fifo_count stays 4, drop=0, and the order is preserved.
REQ-035 Reset: reset_n low mid-REPEAT with 3 moves queued -> move_valid=0 and fifo_count=0 asynchronously; a held key yields one move after release of reset_n.
